// File: rtl/seq_detector_ctrl.sv
// Programmable serial sequence detector: config handshake, shift/compare, match pulse and count.
// Define SEQ_DET_CNT_SAT_EN to make match_count saturate instead of wrapping.
module seq_detector_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic             i_cfg_overlap,
  input  logic             i_din_valid,
  input  logic             i_din,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_busy
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_overlap;
  logic [PAT_W-1:0]  r_history;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [CNT_W-1:0]  r_count;
  logic              r_cfg_ready;
  logic              r_busy;

  logic              w_accept;
  logic [PAT_W-1:0]  w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_hit;
  logic [CNT_W-1:0]  w_count_inc;

  always_comb begin
    w_accept = i_cfg_valid & r_cfg_ready;
    w_hist_n = {r_history[PAT_W-2:0], i_din};
    w_fill_n = (r_fill >= FILL_FULL) ? FILL_FULL : (r_fill + FILL_W'(1));
    // A config accepted in RUN takes priority, so the coincident bit can never hit.
    w_hit    = (r_state == ST_RUN) && i_din_valid && !w_accept &&
               (w_hist_n == r_pattern) && (w_fill_n == FILL_FULL);
`ifdef SEQ_DET_CNT_SAT_EN
    w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : (r_count + CNT_W'(1));
`else
    w_count_inc = r_count + CNT_W'(1);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_overlap   <= 1'b0;
      r_history   <= '0;
      r_fill      <= '0;
      r_match     <= 1'b0;
      r_count     <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_LOAD;
      r_pattern   <= i_cfg_pattern;
      r_overlap   <= i_cfg_overlap;
      r_history   <= '0;
      r_fill      <= '0;
      r_match     <= 1'b0;
      r_count     <= '0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_match     <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        ST_LOAD: begin
          r_state     <= ST_RUN;
          r_history   <= '0;
          r_fill      <= '0;
          r_match     <= 1'b0;
          r_count     <= '0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b1;
        end
        ST_RUN: begin
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b1;
          if (i_din_valid) begin
            r_match <= w_hit;
            if (w_hit) begin
              r_count <= w_count_inc;
              // Non-overlapping mode demands PAT_W fresh bits before the next match.
              if (r_overlap) begin
                r_history <= w_hist_n;
                r_fill    <= w_fill_n;
              end else begin
                r_history <= '0;
                r_fill    <= '0;
              end
            end else begin
              r_history <= w_hist_n;
              r_fill    <= w_fill_n;
            end
          end else begin
            r_match <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_match     <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready   = r_cfg_ready;
  assign o_match       = r_match;
  assign o_match_count = r_count;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_seq_detector_ctrl.sv
// Self-checking bench for seq_detector_ctrl against a queue-based sliding-window model.
// Expected counts follow SEQ_DET_CNT_SAT_EN when it is defined for the build.
module tb_seq_detector_ctrl;

  logic       clk;
  logic       rstN;

  logic       aCfgValid, aCfgReady, aCfgOverlap, aDinValid, aDin, aMatch, aBusy;
  logic [3:0] aCfgPattern;
  logic [7:0] aCount;

  logic       bCfgValid, bCfgReady, bCfgOverlap, bDinValid, bDin, bMatch, bBusy;
  logic [1:0] bCfgPattern;
  logic [1:0] bCount;

  int checks = 0;
  int errors = 0;

  bit       modelRun;
  bit       modelOvl;
  bit [3:0] modelPat;
  bit       modelWin[$];
  int       modelHits;

  seq_detector_ctrl #(.PAT_W(4), .CNT_W(8)) dutA (
    .i_clk(clk), .i_rst_n(rstN),
    .i_cfg_valid(aCfgValid), .o_cfg_ready(aCfgReady),
    .i_cfg_pattern(aCfgPattern), .i_cfg_overlap(aCfgOverlap),
    .i_din_valid(aDinValid), .i_din(aDin),
    .o_match(aMatch), .o_match_count(aCount), .o_busy(aBusy)
  );

  seq_detector_ctrl #(.PAT_W(2), .CNT_W(2)) dutB (
    .i_clk(clk), .i_rst_n(rstN),
    .i_cfg_valid(bCfgValid), .o_cfg_ready(bCfgReady),
    .i_cfg_pattern(bCfgPattern), .i_cfg_overlap(bCfgOverlap),
    .i_din_valid(bDinValid), .i_din(bDin),
    .o_match(bMatch), .o_match_count(bCount), .o_busy(bBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expCount(int hits, int width);
    int maxVal;
    maxVal = (1 << width) - 1;
`ifdef SEQ_DET_CNT_SAT_EN
    return (hits > maxVal) ? maxVal : hits;
`else
    return hits & maxVal;
`endif
  endfunction

  // Match when the last four accepted bits equal the pattern (oldest bit = MSB).
  function automatic bit modelPush(bit b);
    bit hit;
    modelWin.push_back(b);
    if (modelWin.size() > 4) void'(modelWin.pop_front());
    hit = (modelWin.size() == 4);
    for (int i = 0; i < modelWin.size(); i++)
      if (modelWin[i] != modelPat[3-i]) hit = 1'b0;
    if (hit) begin
      modelHits++;
      if (!modelOvl) modelWin.delete();
    end
    return hit;
  endfunction

  task automatic stepA(input bit v, input bit d, input string tag);
    bit expMatch;
    aCfgValid = 1'b0;
    aDinValid = v;
    aDin      = d;
    expMatch  = (modelRun && v) ? modelPush(d) : 1'b0;
    @(posedge clk); #1;
    checks++;
    if (aMatch !== expMatch) begin
      errors++;
      $display("[TB] FAIL %s match: got %b expected %b", tag, aMatch, expMatch);
    end
    checks++;
    if (aCount !== 8'(expCount(modelHits, 8))) begin
      errors++;
      $display("[TB] FAIL %s count: got %0d expected %0d", tag, aCount, expCount(modelHits, 8));
    end
    checks++;
    if (aBusy !== modelRun || aCfgReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s busy/ready: got %b/%b expected %b/1", tag, aBusy, aCfgReady, modelRun);
    end
  endtask

  task automatic cfgA(input bit [3:0] pat, input bit ovl, input bit dv);
    aCfgValid   = 1'b1;
    aCfgPattern = pat;
    aCfgOverlap = ovl;
    aDinValid   = dv;
    aDin        = $urandom_range(0, 1);
    @(posedge clk); #1;
    aCfgValid = 1'b0;
    modelRun  = 1'b1;
    modelOvl  = ovl;
    modelPat  = pat;
    modelHits = 0;
    modelWin.delete();
    checks++;
    if (aCfgReady !== 1'b0 || aBusy !== 1'b1 || aMatch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cfg_load: ready/busy/match got %b/%b/%b expected 0/1/0", aCfgReady, aBusy, aMatch);
    end
    aDinValid = $urandom_range(0, 1);
    aDin      = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (aCfgReady !== 1'b1 || aBusy !== 1'b1 || aMatch !== 1'b0 || aCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL cfg_run: ready/busy/match/count got %b/%b/%b/%0d expected 1/1/0/0",
               aCfgReady, aBusy, aMatch, aCount);
    end
  endtask

  task automatic checkCountA(input int expected, input string tag);
    checks++;
    if (aCount !== 8'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: count got %0d expected %0d", tag, aCount, expected);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    aCfgValid = 1'b0; aCfgPattern = '0; aCfgOverlap = 1'b0; aDinValid = 1'b0; aDin = 1'b0;
    bCfgValid = 1'b0; bCfgPattern = '0; bCfgOverlap = 1'b0; bDinValid = 1'b0; bDin = 1'b0;
    modelRun = 1'b0; modelHits = 0; modelWin.delete();
    #12;
    checks++;
    if (aCfgReady !== 1'b1 || aBusy !== 1'b0 || aMatch !== 1'b0 || aCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset: ready/busy/match/count got %b/%b/%b/%0d expected 1/0/0/0",
               aCfgReady, aBusy, aMatch, aCount);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    stepA(1'b1, 1'b1, "idle_ignore");
    stepA(1'b1, 1'b1, "idle_ignore");
  endtask

  task automatic test_overlap();
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    cfgA(4'b1011, 1'b1, 1'b0);
    foreach (stream[i]) stepA(1'b1, stream[i], "t1_overlap");
    checkCountA(2, "t1_total");
  endtask

  task automatic test_no_overlap();
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    cfgA(4'b1011, 1'b0, 1'b0);
    foreach (stream[i]) stepA(1'b1, stream[i], "t2_nonoverlap");
    checkCountA(1, "t2_total");
  endtask

  task automatic test_gaps();
    cfgA(4'b1011, 1'b1, 1'b0);
    stepA(1'b1, 1'b1, "t3_bit");
    stepA(1'b0, 1'b1, "t3_gap");
    stepA(1'b1, 1'b0, "t3_bit");
    stepA(1'b0, 1'b1, "t3_gap");
    stepA(1'b0, 1'b1, "t3_gap");
    stepA(1'b1, 1'b1, "t3_bit");
    stepA(1'b1, 1'b1, "t3_bit");
    checkCountA(1, "t3_total");
  endtask

  task automatic test_wrap();
    bit expMatch;
    bCfgValid = 1'b1; bCfgPattern = 2'b11; bCfgOverlap = 1'b1;
    @(posedge clk); #1;
    bCfgValid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bDinValid = 1'b1;
      bDin      = 1'b1;
      expMatch  = (i >= 1);
      @(posedge clk); #1;
      checks++;
      if (bMatch !== expMatch || bCount !== 2'(expCount(i, 2))) begin
        errors++;
        $display("[TB] FAIL t4_wrap bit %0d: match/count got %b/%0d expected %b/%0d",
                 i, bMatch, bCount, expMatch, expCount(i, 2));
      end
    end
    bDinValid = 1'b0;
  endtask

  task automatic test_reconfig();
    cfgA(4'b1011, 1'b1, 1'b0);
    stepA(1'b1, 1'b1, "t5_pre");
    stepA(1'b1, 1'b0, "t5_pre");
    stepA(1'b1, 1'b1, "t5_pre");
    cfgA(4'b0110, 1'b1, 1'b1);
    foreach (modelPat[i]) stepA(1'b1, 1'b0, "t5_zero");
    stepA(1'b1, 1'b1, "t5_new");
    stepA(1'b1, 1'b1, "t5_new");
    stepA(1'b1, 1'b0, "t5_new");
    checkCountA(1, "t5_total");
  endtask

  task automatic test_reset_midrun();
    cfgA(4'b1011, 1'b1, 1'b0);
    stepA(1'b1, 1'b1, "t6_pre");
    stepA(1'b1, 1'b0, "t6_pre");
    stepA(1'b1, 1'b1, "t6_pre");
    stepA(1'b1, 1'b1, "t6_pre");
    rstN = 1'b0;
    modelRun = 1'b0; modelHits = 0; modelWin.delete();
    #1;
    checks++;
    if (aCfgReady !== 1'b1 || aBusy !== 1'b0 || aMatch !== 1'b0 || aCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL t6_async: ready/busy/match/count got %b/%b/%b/%0d expected 1/0/0/0",
               aCfgReady, aBusy, aMatch, aCount);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepA(1'b1, 1'b1, "t6_idle");
      stepA(1'b1, 1'b0, "t6_idle");
      stepA(1'b1, 1'b1, "t6_idle");
      stepA(1'b1, 1'b1, "t6_idle");
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      cfgA(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++)
        stepA($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_wrap();
    test_reconfig();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
